// File: rtl/imif_mem_responder_pkg.sv
// Shared encodings for the cache-to-memory request interface responder.
package imif_mem_responder_pkg;

  // Request direction encoding shared with the initiators.
  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // AXI size codes: bytes per beat = 1 << code.
  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRd,
    StWa,
    StWd,
    StResp
  } resp_state_e;

  // Beats wider than the 64-bit data path are not supported.
  function automatic logic size_illegal(input logic [2:0] size);
    return size > AXI_SIZE_8B;
  endfunction

endpackage

// File: rtl/imif_beat_addr_gen.sv
// Burst address generator: latches start address, size and length, then
// steps one beat at a time. The word address wraps modulo the SRAM depth.
module imif_beat_addr_gen
  import imif_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rrst,
  input  logic              load,
  input  logic              advance,
  input  logic [MEM_AW+2:0] start_addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  output logic [MEM_AW-1:0] word_addr,
  output logic              last
);

  logic [MEM_AW+2:0] start_q;
  logic [2:0]        size_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [MEM_AW+2:0] beat_addr;

  // Latch the burst on acceptance, then count beats.
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      start_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      start_q <= start_addr;
      size_q  <= size;
      len_q   <= len;
      cnt_q   <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Beat byte address = start + beat * bytes_per_beat, truncated to the window.
  always_comb begin
    beat_addr = start_q + ((MEM_AW + 3)'(cnt_q) << size_q);
    word_addr = MEM_AW'(beat_addr >> 3);
    last      = (cnt_q == len_q);
  end

endmodule

// File: rtl/imif_mem_responder.sv
// Responder end of the cache-to-memory request interface, serving single-beat
// and burst reads/writes from a synchronous single-port SRAM (1-cycle read).
module imif_mem_responder
  import imif_mem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned MEM_AW    = 16,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rrst,
  input  logic              rw_valid,
  input  logic              rw_req,
  input  logic [31:0]       rw_addr,
  input  logic [2:0]        rw_size,
  input  logic [7:0]        rw_len,
  input  logic [63:0]       rw_w_data,
  input  logic [7:0]        w_strb,
  input  logic              w_last,
  output logic              axi_write_ahead,
  output logic              w_hs,
  output logic              r_hs,
  output logic              r_last,
  output logic [63:0]       data_read,
  output logic              rw_ready,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic [63:0]       mem_rdata
);

  resp_state_e       state_q;
  logic [3:0]        wait_cnt_q;
  logic              addr_err_q;
  logic              proto_err_q;
  logic              is_write_q;
  logic              issued_all_q;
  logic              beat_issued_q;
  logic              beat_last_q;
  logic              rd_en_q;
  logic [MEM_AW-1:0] rd_addr_q;
  logic              write_ahead_q;
  logic              w_hs_q;
  logic              r_hs_q;
  logic              r_last_q;
  logic              rw_ready_q;
  logic              resp_err_q;

  logic              accept;
  logic [31:0]       req_off;
  logic              req_err;
  logic              gen_load;
  logic              gen_advance;
  logic [MEM_AW-1:0] gen_word_addr;
  logic              gen_last;
  logic              wr_en;

  // Request decode: acceptance and window/size error check.
  always_comb begin
    accept  = (state_q == StIdle) && rw_valid && !rw_ready_q;
    req_off = rw_addr - ADDR_BASE;
    req_err = (rw_addr < ADDR_BASE) || ((req_off >> (MEM_AW + 3)) != 32'd0) ||
              size_illegal(rw_size);
    gen_load    = accept;
    gen_advance = ((state_q == StRd) && !issued_all_q && !gen_last) ||
                  ((state_q == StWd) && !gen_last);
  end

  imif_beat_addr_gen #(
    .MEM_AW(MEM_AW)
  ) u_beat_addr_gen (
    .clk       (clk),
    .rrst      (rrst),
    .load      (gen_load),
    .advance   (gen_advance),
    .start_addr(rw_addr[MEM_AW+2:0]),
    .size      (rw_size),
    .len       (rw_len),
    .word_addr (gen_word_addr),
    .last      (gen_last)
  );

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      addr_err_q    <= 1'b0;
      proto_err_q   <= 1'b0;
      is_write_q    <= 1'b0;
      issued_all_q  <= 1'b0;
      beat_issued_q <= 1'b0;
      beat_last_q   <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      write_ahead_q <= 1'b0;
      w_hs_q        <= 1'b0;
      r_hs_q        <= 1'b0;
      r_last_q      <= 1'b0;
      rw_ready_q    <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_err_q   <= req_err;
            proto_err_q  <= 1'b0;
            is_write_q   <= (rw_req == REQ_WRITE);
            wait_cnt_q   <= '0;
            issued_all_q <= 1'b0;
            rd_addr_q    <= '0;
            if (LATENCY == 0) begin
              if (rw_req == REQ_WRITE) begin
                state_q       <= StWa;
                write_ahead_q <= 1'b1;
              end else begin
                state_q <= StRd;
              end
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (wait_cnt_q == 4'(LATENCY - 1)) begin
            if (is_write_q) begin
              state_q       <= StWa;
              write_ahead_q <= 1'b1;
            end else begin
              state_q <= StRd;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        StRd: begin
          // Issue stage: one SRAM read per cycle until the last beat is issued.
          beat_issued_q <= !issued_all_q;
          beat_last_q   <= !issued_all_q && gen_last;
          rd_en_q       <= !issued_all_q && !addr_err_q;
          if (!issued_all_q) begin
            rd_addr_q <= gen_word_addr;
            if (gen_last) begin
              issued_all_q <= 1'b1;
            end
          end
          // Return stage trails the issue stage by the SRAM's one-cycle latency.
          r_hs_q   <= beat_issued_q;
          r_last_q <= beat_last_q;
          if (r_last_q) begin
            state_q    <= StResp;
            rw_ready_q <= 1'b1;
            resp_err_q <= addr_err_q;
            r_hs_q     <= 1'b0;
            r_last_q   <= 1'b0;
          end
        end
        StWa: begin
          state_q       <= StWd;
          write_ahead_q <= 1'b0;
          w_hs_q        <= 1'b1;
        end
        StWd: begin
          // The burst length is fixed at acceptance; a misplaced w_last only flags.
          if (w_last != gen_last) begin
            proto_err_q <= 1'b1;
          end
          if (gen_last) begin
            state_q    <= StResp;
            w_hs_q     <= 1'b0;
            rw_ready_q <= 1'b1;
            resp_err_q <= addr_err_q || proto_err_q || !w_last;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          rw_ready_q <= 1'b0;
          resp_err_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // SRAM port mux: registered read issue, write beats pass straight through.
  always_comb begin
    wr_en     = (state_q == StWd) && !addr_err_q;
    mem_en    = rd_en_q || wr_en;
    mem_we    = wr_en;
    mem_addr  = wr_en ? gen_word_addr : rd_addr_q;
    mem_wdata = wr_en ? rw_w_data : 64'd0;
    mem_wstrb = wr_en ? w_strb : 8'd0;
    data_read = (r_hs_q && !addr_err_q) ? mem_rdata : 64'd0;
  end

  assign axi_write_ahead = write_ahead_q;
  assign w_hs            = w_hs_q;
  assign r_hs            = r_hs_q;
  assign r_last          = r_last_q;
  assign rw_ready        = rw_ready_q;
  assign resp_err        = resp_err_q;

endmodule

// File: doc/imif_mem_responder.md
Name: imif_mem_responder

Overview:
- Responder (slave) end of the cache-to-memory request interface: accepts single-beat and burst read/write requests from an initiator such as the data or instruction cache.
- Services each request against a synchronous single-port SRAM with one-cycle read latency.
- Returns read beats and accepts write beats with per-beat handshakes and a one-cycle end-of-transaction `rw_ready` pulse.
- Used as on-chip scratch memory and as the bench-side memory model for cache verification.

Parameters:
- ADDR_BASE, 32'h8000_0000, first byte address served.
- MEM_AW, 16, SRAM word-address width (64-bit words); served window is 2^(MEM_AW+3) bytes.
- LATENCY, 2, idle cycles inserted between request acceptance and first beat (0..15).

Ports:
- clk  in  1  clock
- rrst  in  1  asynchronous reset, active-high
- rw_valid  in  1  request valid; held by initiator until rw_ready
- rw_req  in  1  REQ_READ / REQ_WRITE (shared package encoding)
- rw_addr  in  32  start byte address
- rw_size  in  3  AXI size code, bytes per beat = 1<<rw_size, max 8
- rw_len  in  8  beats minus one
- rw_w_data  in  64  write beat data
- w_strb  in  8  write byte strobes
- w_last  in  1  initiator marks final write beat
- axi_write_ahead  out  1  one-cycle pulse the cycle before the first write beat
- w_hs  out  1  write beat accepted this cycle
- r_hs  out  1  data_read valid this cycle
- r_last  out  1  current read beat is final
- data_read  out  64  read beat data, full aligned 64-bit word
- rw_ready  out  1  one-cycle transaction-complete pulse
- resp_err  out  1  sticky-for-one-pulse error, valid with rw_ready
- mem_en, mem_we  out  1 each  SRAM enable, write enable
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  64  SRAM write data
- mem_wstrb  out  8  SRAM byte enables
- mem_rdata  in  64  SRAM data, valid one cycle after mem_en && !mem_we

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; counters 0. Reset mid-burst aborts the burst with no rw_ready.
- IDLE: when rw_valid=1 and rw_ready=0, latch addr/size/len/req. Compute err = addr outside [ADDR_BASE, ADDR_BASE+2^(MEM_AW+3)) or size>3. Go to WAIT, or to the first data state if LATENCY=0.
- WAIT: count LATENCY cycles, then go to RD (read) or WA (write).
- RD:
  - Issue mem_en each cycle for beat i, i=0..len; beat byte address = addr + i*(1<<size).
  - mem_addr = beat address bits [MEM_AW+2:3]; wraps modulo the SRAM depth.
  - r_hs asserts the cycle after each issue, with data_read = mem_rdata; r_last accompanies beat len.
  - Go to RESP after the r_last cycle.
  - If err: no mem_en; data_read=0; beat timing unchanged.
- WA: axi_write_ahead=1 for exactly one cycle, then go to WD.
- WD:
  - w_hs=1 every cycle for beats 0..len.
  - mem_en=mem_we=1 with mem_wdata=rw_w_data and mem_wstrb=w_strb (mem_en suppressed when err).
  - After beat len, go to RESP.
  - If w_last disagrees with the beat counter (w_last early, or absent on beat len), set err; the burst still runs len+1 beats.
- RESP: rw_ready=1 and resp_err=err for one cycle, then IDLE. rw_valid is ignored during RESP, so the same request is not re-accepted.
- Narrow accesses (size<3): a whole aligned word is returned; the initiator selects the lane from addr[2:0]. Write strobes are taken as given, with no realignment.
- rw_valid dropping mid-transaction is a protocol violation: ignored, and the transaction completes.
- Read latency: first r_hs at LATENCY+2 cycles after the accept edge.
- Beat counter is 8 bits; len=255 is legal.

Decomposition:
- Shared package: REQ_READ/REQ_WRITE constants, AXI_SIZE codes, and the responder state enum (IDLE, WAIT, RD, WA, WD, RESP).
- One natural sub-module, imif_beat_addr_gen: holds the start address, size and beat count, and produces the beat address, last flag and wrap.
- The SRAM itself is external.

Test Plan:
- 8-beat read at 0x8000_0040, size 3, LATENCY=2, SRAM preloaded with word k = k: first r_hs 4 cycles after accept; data_read 8,9,…,15 on consecutive cycles; r_last on the 8th beat; rw_ready the next cycle; resp_err=0.
- 8-beat write at 0x8000_0080, w_last on beat 7: axi_write_ahead is one cycle before the first w_hs; 8 consecutive w_hs; SRAM words 16..23 updated; rw_ready with resp_err=0.
- Single 4-byte write at 0x8000_0004, w_strb=8'hF0, data 64'hAABBCCDD_00000000: only the upper 4 bytes of word 0 change; a following read of word 0 returns the merged value.
- Read at 0x1000_0000: no mem_en; 1 beat of zeros; rw_ready with resp_err=1.
- Write with len=7 but w_last asserted on beat 3: 8 w_hs pulses occur; resp_err=1.
- rrst asserted during beat 4 of a read: outputs go to 0 immediately; no rw_ready; the next request is serviced normally from IDLE.
